tdc_counter_readout: RTL



---
 rtl/tdc_counter_readout.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/tdc_counter_readout.sv
// Stop-pulse capture of per-channel coarse counters with sticky hit/overrun flags,
// read back as an 8-bit ready/valid byte stream (snapshot bytes or flag bytes).
module tdc_counter_readout #(
    parameter int NCH   = 8,
    parameter int CNT_W = 27,
    parameter int SEL_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NCH-1:0]         tc,
    input  logic [NCH*CNT_W-1:0]   counter,
    input  logic                   rd_start,
    input  logic                   rd_flags,
    input  logic [SEL_W-1:0]       rd_ch,
    output logic [7:0]             dout,
    output logic                   dout_valid,
    output logic                   dout_last,
    input  logic                   dout_ready,
    output logic                   busy,
    output logic [NCH-1:0]         hit,
    output logic [NCH-1:0]         overrun
);
    localparam int unsigned NBYTES = (CNT_W + 7) / 8;
    localparam int unsigned NFB    = (NCH + 7) / 8;
    localparam int unsigned NFLAGB = 2 * NFB;
    localparam int unsigned SNAP_W = NBYTES * 8;
    localparam int unsigned IDX_W  = 4;
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(NBYTES - 1);
    localparam logic [IDX_W-1:0] LAST_FLAG = IDX_W'(NFLAGB - 1);

    typedef enum logic [1:0] {IDLE, DATA, FLAGS} state_t;

    logic [NCH-1:0]    sync1_q, sync2_q, sync3_q, stop_q;
    logic [NCH-1:0]    hit_q, hit_d, ovr_q, ovr_d, clr_vec;
    logic [SNAP_W-1:0] snap_q [NCH];
    logic [SNAP_W-1:0] snap_d [NCH];

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [SEL_W-1:0]  ch_q, ch_d;
    logic [7:0]        dout_q, dout_d;
    logic              valid_q, valid_d, last_q, last_d, busy_q, busy_d;

    logic              ch_ok, rd_clr;
    logic [SNAP_W-1:0] sel_snap;
    logic [NFLAGB*8-1:0] flag_vec;
    logic [7:0]        byte_v;

    if (NCH == (1 << SEL_W)) begin : g_full_sel
        assign ch_ok = 1'b1;
    end else begin : g_part_sel
        assign ch_ok = (int'(ch_q) < NCH);
    end

    assign sel_snap = ch_ok ? snap_q[ch_q] : '0;
    assign rd_clr   = (state_q == DATA) && valid_q && dout_ready && last_q && ch_ok;

    always_comb begin
        flag_vec = '0;
        flag_vec[NCH-1:0] = hit_q;
        flag_vec[NFB*8 +: NCH] = ovr_q;
    end

    always_comb begin
        byte_v = '0;
        for (int unsigned b = 0; b < NBYTES; b++) begin
            if (state_q == DATA && idx_q == b[IDX_W-1:0]) byte_v = sel_snap[b*8 +: 8];
        end
        for (int unsigned b = 0; b < NFLAGB; b++) begin
            if (state_q == FLAGS && idx_q == b[IDX_W-1:0]) byte_v = flag_vec[b*8 +: 8];
        end
    end

    // A stop coinciding with clear-on-read re-arms the channel with a fresh snapshot.
    always_comb begin
        hit_d   = hit_q;
        ovr_d   = ovr_q;
        clr_vec = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            snap_d[i]  = snap_q[i];
            clr_vec[i] = rd_clr && (ch_q == i[SEL_W-1:0]);
            if (stop_q[i]) begin
                if (!hit_q[i] || clr_vec[i]) begin
                    snap_d[i] = '0;
                    snap_d[i][CNT_W-1:0] = counter[i*CNT_W +: CNT_W];
                    hit_d[i] = 1'b1;
                end
                if (clr_vec[i])    ovr_d[i] = 1'b0;
                else if (hit_q[i]) ovr_d[i] = 1'b1;
            end else if (clr_vec[i]) begin
                hit_d[i] = 1'b0;
                ovr_d[i] = 1'b0;
            end
        end
    end

    // Request is latched in IDLE; the first byte and busy register one edge later.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ch_d    = ch_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        unique case (state_q)
            IDLE: begin
                if (rd_start) begin
                    ch_d    = rd_ch;
                    idx_d   = '0;
                    state_d = rd_flags ? FLAGS : DATA;
                end
            end
            DATA, FLAGS: begin
                if (valid_q && dout_ready && last_q) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    dout_d  = '0;
                    busy_d  = 1'b0;
                end else if (!valid_q || dout_ready) begin
                    dout_d  = byte_v;
                    valid_d = 1'b1;
                    last_d  = (idx_q == ((state_q == FLAGS) ? LAST_FLAG : LAST_DATA));
                    idx_d   = idx_q + 1'b1;
                    busy_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
            stop_q  <= '0;
            hit_q   <= '0;
            ovr_q   <= '0;
            for (int unsigned i = 0; i < NCH; i++) snap_q[i] <= '0;
            state_q <= IDLE;
            idx_q   <= '0;
            ch_q    <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync1_q <= tc;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            stop_q  <= sync2_q & ~sync3_q;
            hit_q   <= hit_d;
            ovr_q   <= ovr_d;
            for (int unsigned i = 0; i < NCH; i++) snap_q[i] <= snap_d[i];
            state_q <= state_d;
            idx_q   <= idx_d;
            ch_q    <= ch_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign dout_last  = last_q;
    assign busy       = busy_q;
    assign hit        = hit_q;
    assign overrun    = ovr_q;

endmodule
